serv_mac_mul: RTL and testbench

Bit-serial multiplier that produces the product operand for the ALU's MAC second step. During the first MAC step it captures rs1 and op_b as they stream past, LSB first. It then computes the low 32 bits of their product with a shift-add sequencer. During the second step it streams the product, LSB first, on `o_buf`, which the ALU adds in place of rs1.

---
 rtl/serv_mac_mul_if.sv | 21 ++
 rtl/serv_mac_mul.sv | 79 +++++++
 tb/tb_serv_mac_mul.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serv_mac_mul_if.sv
// serv_mac_mul_if: core-side handshake and serial data bundle for the MAC multiplier.
interface serv_mac_mul_if #(
   parameter int W = 1
);
   logic         i_start;
   logic         i_en;
   logic         i_MAC_step2;
   logic [W-1:0] i_rs1;
   logic [W-1:0] i_op_b;
   logic         o_busy;
   logic         o_ready;
   logic [W-1:0] o_buf;
   modport master (
      output i_start, i_en, i_MAC_step2, i_rs1, i_op_b,
      input  o_busy, o_ready, o_buf
   );
   modport slave (
      input  i_start, i_en, i_MAC_step2, i_rs1, i_op_b,
      output o_busy, o_ready, o_buf
   );
endinterface

// File: rtl/serv_mac_mul.sv
// serv_mac_mul: bit-serial shift-add multiplier feeding the ALU's MAC second step.
// Optional SERV_MAC_EARLY_TERM_EN ends MUL as soon as the remaining multiplier is zero.
module serv_mac_mul #(
   parameter int W = 1,
   parameter int B = W - 1
) (
   input logic         clk,
   input logic         i_rst,
   serv_mac_mul_if.slave bus
);
   localparam int N  = 32 / W;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;
   state_t        state, nxt;
   logic [31:0]   a, m, p;
   logic [CW-1:0] cnt;
   logic [4:0]    mcnt;
   logic          last, take, mul_end;
   assign last = cnt == CW'(N - 1);
   assign take = bus.i_en & bus.i_MAC_step2;
`ifdef SERV_MAC_EARLY_TERM_EN
   assign mul_end = (&mcnt) | (m[31:1] == 31'd0);
`else
   assign mul_end = &mcnt;
`endif
   always_ff @(posedge clk) begin
      if (i_rst) state <= IDLE;
      else state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = bus.i_start ? LOAD : IDLE;
         LOAD: nxt = (bus.i_en && last) ? MUL : LOAD;
         MUL:  nxt = mul_end ? DONE : MUL;
         DONE: nxt = (take && last) ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   // The beat counter wraps to zero at the end of LOAD, so DONE reuses it for the stream.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         a    <= '0;
         m    <= '0;
         p    <= '0;
         cnt  <= '0;
         mcnt <= '0;
      end else begin
         case (state)
            IDLE: if (bus.i_start) begin
               a    <= '0;
               m    <= '0;
               p    <= '0;
               cnt  <= '0;
               mcnt <= '0;
            end
            LOAD: if (bus.i_en) begin
               a   <= {bus.i_rs1, a[31:W]};
               m   <= {bus.i_op_b, m[31:W]};
               cnt <= cnt + CW'(1);
            end
            MUL: begin
               if (m[0]) p <= p + a;
               a    <= a << 1;
               m    <= m >> 1;
               mcnt <= mcnt + 5'd1;
            end
            DONE: if (take) begin
               p   <= last ? '0 : p >> W;
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end
   assign bus.o_busy  = (state == LOAD) || (state == MUL);
   assign bus.o_ready = state == DONE;
   assign bus.o_buf   = bus.o_ready ? p[B:0] : '0;
endmodule

// File: tb/tb_serv_mac_mul.sv
// tb_serv_mac_mul: directed scoreboard bench driving a W=1 and a W=4 multiplier.
module tb_serv_mac_mul;
   logic        clk = 0;
   logic        i_rst = 1;
   logic        sel = 0, start = 0, en = 0, step2 = 0;
   logic [31:0] sh_a = 0, sh_b = 0;
   logic [31:0] exp_q[$];
   logic [31:0] acc = 0, e;
   int          nb = 0, bw_m;
   int          checks = 0, errors = 0;
   logic        busy, ready;
   logic [3:0]  obuf;

   always #5 clk = ~clk;

   serv_mac_mul_if #(.W(1)) b1 ();
   serv_mac_mul_if #(.W(4)) b4 ();
   assign b1.i_start     = start & ~sel;
   assign b1.i_en        = en & ~sel;
   assign b1.i_MAC_step2 = step2 & ~sel;
   assign b1.i_rs1       = sh_a[0:0];
   assign b1.i_op_b      = sh_b[0:0];
   assign b4.i_start     = start & sel;
   assign b4.i_en        = en & sel;
   assign b4.i_MAC_step2 = step2 & sel;
   assign b4.i_rs1       = sh_a[3:0];
   assign b4.i_op_b      = sh_b[3:0];
   serv_mac_mul #(.W(1)) u1 (.clk(clk), .i_rst(i_rst), .bus(b1.slave));
   serv_mac_mul #(.W(4)) u4 (.clk(clk), .i_rst(i_rst), .bus(b4.slave));
   assign busy  = sel ? b4.o_busy : b1.o_busy;
   assign ready = sel ? b4.o_ready : b1.o_ready;
   assign obuf  = sel ? b4.o_buf : {3'b000, b1.o_buf};

   // Monitor: rebuild each streamed product and compare it with the oldest expectation.
   always @(negedge clk) begin
      bw_m = sel ? 4 : 1;
      if (i_rst) begin
         acc = 0;
         nb  = 0;
      end else if (ready && en && step2) begin
         acc = acc | (32'(obuf) << (nb * bw_m));
         nb++;
         if (nb == 32 / bw_m) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL product: got %h, nothing expected", acc);
            end else begin
               e = exp_q.pop_front();
               if (acc !== e) begin
                  errors++;
                  $display("FAIL product: got %h expected %h", acc, e);
               end
            end
            acc = 0;
            nb  = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, ex);
      end
   endtask

   function automatic int mul_len(input logic [31:0] b);
      int n;
      n = 32;
`ifdef SERV_MAC_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`endif
      return n;
   endfunction

   task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [31:0] ex,
                     input int gap_at, input int gap_len, input bit s2l, input bit sp);
      int  bw, n, cyc, lat;
      bit  bad;
      sel = s;
      bw  = s ? 4 : 1;
      n   = 32 / bw;
      exp_q.push_back(ex);
      sh_a  = a;
      sh_b  = b;
      start = 1;
      tick;
      start = 0;
      cyc   = 1;
      bad   = 0;
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) repeat (gap_len) begin
            en = 0;
            tick;
            cyc++;
         end
         en    = 1;
         step2 = s2l;
         @(negedge clk);
         if (obuf !== 4'd0 || busy !== 1'b1) bad = 1;
         tick;
         cyc++;
         sh_a = sh_a >> bw;
         sh_b = sh_b >> bw;
      end
      en    = 0;
      step2 = 0;
      if (s2l) chk("load_buf_zero", 32'(bad), 32'd0);
      lat = 1 + n + gap_len + mul_len(b);
      while (!ready && cyc < 200) begin
         start = sp && (cyc == n + gap_len + 3);
         tick;
         start = 0;
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(lat));
      if (sp) begin
         repeat (3) begin
            start = 1;
            tick;
            start = 0;
         end
         @(negedge clk);
         chk("done_hold", 32'({busy, ready}), 32'd1);
         tick;
      end
      step2 = 1;
      en    = 1;
      repeat (n) tick;
      en    = 0;
      step2 = 0;
      @(negedge clk);
      chk("ready_fall", 32'({busy, ready, obuf}), 32'd0);
      tick;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (2) tick;
      i_rst = 0;
      @(negedge clk);
      chk("reset_w1", 32'({b1.o_busy, b1.o_ready, b1.o_buf}), 32'd0);
      chk("reset_w4", 32'({b4.o_busy, b4.o_ready, b4.o_buf}), 32'd0);
      tick;
      op(0, 32'd3, 32'd5, 32'h0000000F, 0, 0, 0, 0);
      op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0);
      op(0, 32'h12345678, 32'h00000010, 32'h23456780, 0, 0, 0, 0);
      op(1, 32'h12345678, 32'h00000010, 32'h23456780, 0, 0, 0, 0);
      op(0, 32'd3, 32'd5, 32'h0000000F, 10, 5, 0, 0);
      sel   = 0;
      sh_a  = 32'h0000FFFF;
      sh_b  = 32'h80000001;
      start = 1;
      tick;
      start = 0;
      for (int k = 0; k < 32; k++) begin
         en = 1;
         tick;
         sh_a = sh_a >> 1;
         sh_b = sh_b >> 1;
      end
      en = 0;
      repeat (9) tick;
      chk("mul_busy", 32'({busy, ready}), 32'd2);
      i_rst = 1;
      tick;
      i_rst = 0;
      @(negedge clk);
      chk("reset_mid_mul", 32'({busy, ready, obuf}), 32'd0);
      tick;
      op(0, 32'd7, 32'd6, 32'd42, 0, 0, 0, 0);
      op(0, 32'h00001234, 32'h80000003, 32'h0000369C, 0, 0, 0, 1);
      op(0, 32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 0, 0, 1, 0);
      op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0);
      op(1, 32'd7, 32'd0, 32'd0, 0, 0, 0, 0);
      op(1, 32'd3, 32'd5, 32'h0000000F, 3, 2, 1, 1);
      op(0, 32'd1, 32'h80000000, 32'h80000000, 0, 0, 0, 0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
